// File: rtl/viterbi_pkg.sv
// Shared definitions for the Viterbi frame controller, its counters and the bench.
package viterbi_pkg;

    localparam int unsigned TBL_DEF   = 32;
    localparam int unsigned LEN_W_DEF = 10;

    typedef logic [2:0] state_t;

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StClear = 3'd1;
    localparam logic [2:0] StFeed  = 3'd2;
    localparam logic [2:0] StFlush = 3'd3;
    localparam logic [2:0] StDrain = 3'd4;
    localparam logic [2:0] StDone  = 3'd5;

endpackage

// File: rtl/viterbi_frame_cnt.sv
// Up-counter with synchronous clear, enable and a terminal-match strobe.
module viterbi_frame_cnt #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] match_i,
    output logic [WIDTH-1:0] count_o,
    output logic             hit_o
);

    localparam logic [WIDTH:0] ONE = 1;

    logic [WIDTH-1:0] count_q;
    logic [WIDTH:0]   count_inc;

    assign count_inc = {1'b0, count_q} + ONE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (clr_i) begin
            count_q <= '0;
        end else if (en_i) begin
            count_q <= count_inc[WIDTH-1:0];
        end
    end

    // Fires on the increment that makes the count equal match_i.
    assign hit_o   = en_i && (count_inc == {1'b0, match_i});
    assign count_o = count_q;

endmodule

// File: rtl/viterbi_frame_ctrl.sv
// Frame sequencer around a Viterbi core: clear, feed, flush with zeros, drain decoded bits.
module viterbi_frame_ctrl
    import viterbi_pkg::*;
#(
    parameter int unsigned TBL       = TBL_DEF,
    parameter int unsigned LEN_W     = LEN_W_DEF,
    parameter int unsigned DRAIN_MAX = 4 * TBL
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [LEN_W-1:0] frame_len_i,
    input  logic             sym_valid_i,
    input  logic [1:0]       sym_i,
    output logic             sym_ready_o,
    output logic             core_valid_o,
    output logic [1:0]       core_data_o,
    output logic             core_clr_o,
    input  logic             core_bit_i,
    input  logic             core_bit_valid_i,
    output logic             bit_o,
    output logic             bit_valid_o,
    output logic             last_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             timeout_o
);

    localparam int unsigned AUX_MAX = (DRAIN_MAX > TBL) ? DRAIN_MAX : TBL;
    localparam int unsigned AUX_W   = $clog2(AUX_MAX + 1);

    state_t           state_q, state_d;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] in_cnt, out_cnt;
    logic [AUX_W-1:0] aux_cnt, aux_match;
    logic             in_hit, out_hit, aux_hit;
    logic             start_frame, sym_accept, flush_sym, bit_accept;
    logic             aux_run, aux_clr;
    logic             timeout_d, timeout_q;
    logic             bit_q, bit_valid_q, last_q;

    assign start_frame = (state_q == StIdle) && start_i && (frame_len_i != '0);
    assign sym_accept  = (state_q == StFeed) && sym_valid_i && (in_cnt != len_q);
    assign flush_sym   = (state_q == StFlush) && (aux_cnt < AUX_W'(TBL));
    assign bit_accept  = core_bit_valid_i && (out_cnt < len_q) &&
                         ((state_q == StFeed) || (state_q == StFlush) || (state_q == StDrain));

    // One counter serves both the flush length and the drain wait; it restarts at DRAIN entry.
    assign aux_run   = (state_q == StFlush) || (state_q == StDrain);
    assign aux_clr   = !aux_run || ((state_q == StFlush) && aux_hit);
    assign aux_match = (state_q == StFlush) ? AUX_W'(TBL) : AUX_W'(DRAIN_MAX);

    viterbi_frame_cnt #(.WIDTH(LEN_W)) u_in_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (start_frame),
        .en_i    (sym_accept),
        .match_i (len_q),
        .count_o (in_cnt),
        .hit_o   (in_hit)
    );

    viterbi_frame_cnt #(.WIDTH(LEN_W)) u_out_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (start_frame),
        .en_i    (bit_accept),
        .match_i (len_q),
        .count_o (out_cnt),
        .hit_o   (out_hit)
    );

    viterbi_frame_cnt #(.WIDTH(AUX_W)) u_aux_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (aux_clr),
        .en_i    (aux_run),
        .match_i (aux_match),
        .count_o (aux_cnt),
        .hit_o   (aux_hit)
    );

    always_comb begin
        state_d   = state_q;
        timeout_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = (frame_len_i != '0) ? StClear : StDone;
                end
            end
            StClear: state_d = StFeed;
            StFeed: begin
                if (in_hit) begin
                    state_d = StFlush;
                end
            end
            StFlush: begin
                if (aux_hit) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                // Completion wins over a coincident timeout.
                if (out_cnt == len_q) begin
                    state_d = StDone;
                end else if (aux_hit) begin
                    state_d   = StDone;
                    timeout_d = 1'b1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            len_q       <= '0;
            timeout_q   <= 1'b0;
            bit_q       <= 1'b0;
            bit_valid_q <= 1'b0;
            last_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            timeout_q   <= timeout_d;
            bit_valid_q <= bit_accept;
            bit_q       <= bit_accept && core_bit_i;
            last_q      <= out_hit;
            if (start_frame) begin
                len_q <= frame_len_i;
            end
        end
    end

    assign sym_ready_o  = (state_q == StFeed);
    assign core_valid_o = sym_accept || flush_sym;
    assign core_data_o  = sym_accept ? sym_i : 2'b00;
    assign core_clr_o   = (state_q == StClear);
    assign busy_o       = (state_q != StIdle);
    assign done_o       = (state_q == StDone);
    assign timeout_o    = timeout_q;
    assign bit_o        = bit_q;
    assign bit_valid_o  = bit_valid_q;
    assign last_o       = last_q;

endmodule

// File: tb/tb_viterbi_frame_ctrl.sv
// Frame-level self-checking bench for viterbi_frame_ctrl with a behavioural core model.
module tb_viterbi_frame_ctrl;
    import viterbi_pkg::*;

    localparam int unsigned TBL       = TBL_DEF;
    localparam int unsigned LEN_W     = LEN_W_DEF;
    localparam int unsigned DRAIN_MAX = 4 * TBL;
    localparam int          BUDGET    = 2000;

    logic             clk = 1'b0;
    logic             rst;
    logic             start_i;
    logic [LEN_W-1:0] frame_len_i;
    logic             sym_valid_i;
    logic [1:0]       sym_i;
    logic             sym_ready_o;
    logic             core_valid_o;
    logic [1:0]       core_data_o;
    logic             core_clr_o;
    logic             core_bit_i;
    logic             core_bit_valid_i;
    logic             bit_o, bit_valid_o, last_o, busy_o, done_o, timeout_o;

    viterbi_frame_ctrl #(
        .TBL       (TBL),
        .LEN_W     (LEN_W),
        .DRAIN_MAX (DRAIN_MAX)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .start_i          (start_i),
        .frame_len_i      (frame_len_i),
        .sym_valid_i      (sym_valid_i),
        .sym_i            (sym_i),
        .sym_ready_o      (sym_ready_o),
        .core_valid_o     (core_valid_o),
        .core_data_o      (core_data_o),
        .core_clr_o       (core_clr_o),
        .core_bit_i       (core_bit_i),
        .core_bit_valid_i (core_bit_valid_i),
        .bit_o            (bit_o),
        .bit_valid_o      (bit_valid_o),
        .last_o           (last_o),
        .busy_o           (busy_o),
        .done_o           (done_o),
        .timeout_o        (timeout_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    function automatic void chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    // Core model: delay line (mode 0), silent (mode 1), random strobes (mode 2).
    int         cyc = 0;
    logic [TBL-1:0] dl_v = '0;
    logic [TBL-1:0] dl_b = '0;
    int         core_mode = 0;
    int         strobe_den = 2;
    logic [1:0] src_q[$];
    int         gap = 0;
    int         gap_left = 0;

    // Per-frame observations.
    logic [1:0] fwd_q[$];
    logic       strobe_q[$];
    logic       out_q[$];
    int n_clr, n_done, n_to, n_last, last_idx, stray_last;
    int done_cyc, to_cyc, flush_cyc, last_acc_cyc;

    task automatic clear_rec();
        fwd_q.delete();
        strobe_q.delete();
        out_q.delete();
        n_clr = 0; n_done = 0; n_to = 0; n_last = 0; last_idx = -1; stray_last = 0;
        done_cyc = -1; to_cyc = -1; flush_cyc = -1; last_acc_cyc = -1;
    endtask

    task automatic cycle(input logic st, input int ln);
        logic win;
        @(negedge clk);
        start_i     = st;
        frame_len_i = st ? LEN_W'(ln) : LEN_W'($urandom);
        case (core_mode)
            0: begin
                core_bit_valid_i = dl_v[TBL-1];
                core_bit_i       = dl_b[TBL-1];
            end
            2: begin
                core_bit_valid_i = ($urandom_range(0, strobe_den - 1) == 0);
                core_bit_i       = 1'($urandom);
            end
            default: begin
                core_bit_valid_i = 1'b0;
                core_bit_i       = 1'($urandom);
            end
        endcase
        sym_valid_i = (src_q.size() > 0) && (gap_left == 0);
        sym_i       = (src_q.size() > 0) ? src_q[0] : 2'($urandom);
        #1;
        // Strobes count only while the frame is feeding, flushing or draining.
        win = busy_o && !core_clr_o && !done_o;
        if (core_clr_o) n_clr++;
        if (core_valid_o) begin
            fwd_q.push_back(core_data_o);
            if (!sym_ready_o && flush_cyc < 0) flush_cyc = cyc;
        end
        if (core_bit_valid_i && win) strobe_q.push_back(core_bit_i);
        if (bit_valid_o) begin
            if (last_o) begin
                n_last++;
                last_idx = out_q.size();
            end
            out_q.push_back(bit_o);
        end else if (last_o) begin
            stray_last++;
        end
        if (done_o) begin
            n_done++;
            done_cyc = cyc;
        end
        if (timeout_o) begin
            n_to++;
            to_cyc = cyc;
        end
        if (sym_valid_i && sym_ready_o) begin
            void'(src_q.pop_front());
            last_acc_cyc = cyc;
            gap_left = gap;
        end else if (gap_left > 0) begin
            gap_left--;
        end
        dl_v = core_clr_o ? '0 : {dl_v[TBL-2:0], core_valid_o};
        dl_b = core_clr_o ? '0 : {dl_b[TBL-2:0], ^core_data_o};
        cyc++;
    endtask

    task automatic run_frame(input string tag, input int len, input int g, input int mode,
                             input int den, input bit inj);
        logic [1:0] sent[$];
        int  start_cyc;
        int  bad;
        int  nb;
        bit  injected;
        bit  fed;
        bit  exp_to;
        injected = 1'b0;
        fed = 1'b0;
        clear_rec();
        core_mode  = mode;
        strobe_den = den;
        gap        = g;
        gap_left   = 0;
        for (int i = 0; i < len; i++) sent.push_back(2'($urandom));
        src_q = sent;
        start_cyc = cyc;
        cycle(1'b1, len);
        for (int k = 0; k < BUDGET && n_done == 0; k++) begin
            if (inj && fed && !injected) begin
                injected = 1'b1;
                cycle(1'b1, (len % 500) + 7);
            end else begin
                cycle(1'b0, 0);
            end
            if (sym_ready_o) fed = 1'b1;
        end
        for (int i = 0; i < 4; i++) cycle(1'b0, 0);

        exp_to = (len != 0) && (strobe_q.size() < len);
        chk({tag, " clr_count"}, n_clr, (len != 0) ? 1 : 0);
        chk({tag, " core_valid_count"}, fwd_q.size(), (len == 0) ? 0 : len + TBL);
        bad = 0;
        for (int i = 0; i < fwd_q.size(); i++) begin
            if (fwd_q[i] != ((i < len) ? sent[i] : 2'b00)) bad++;
        end
        chk({tag, " core_data_errs"}, bad, 0);
        nb = exp_to ? strobe_q.size() : len;
        chk({tag, " bit_count"}, out_q.size(), nb);
        bad = 0;
        for (int i = 0; i < out_q.size() && i < strobe_q.size(); i++) begin
            if (out_q[i] != strobe_q[i]) bad++;
        end
        chk({tag, " bit_value_errs"}, bad, 0);
        chk({tag, " last_count"}, n_last, (exp_to || len == 0) ? 0 : 1);
        if (n_last == 1) chk({tag, " last_pos"}, last_idx, len - 1);
        chk({tag, " stray_last"}, stray_last, 0);
        chk({tag, " done_count"}, n_done, 1);
        chk({tag, " timeout_count"}, n_to, exp_to ? 1 : 0);
        if (len == 0) chk({tag, " done_latency"}, done_cyc - start_cyc, 1);
        else chk({tag, " flush_start"}, flush_cyc - last_acc_cyc, 1);
        if (exp_to) begin
            chk({tag, " timeout_latency"}, to_cyc - flush_cyc, TBL + DRAIN_MAX);
            chk({tag, " timeout_with_done"}, to_cyc, done_cyc);
        end
    endtask

    typedef struct {
        int len;
        int gap;
        int mode;
        int den;
        bit inj;
        int exp_cv;
        int exp_bits;
        bit exp_to;
    } vec_t;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vecs[7];
        string tag;
        int r;
        vecs[0] = '{8,    0, 0, 2, 1'b0, 40,   8,    1'b0};
        vecs[1] = '{5,    3, 0, 2, 1'b0, 37,   5,    1'b0};
        vecs[2] = '{0,    0, 0, 2, 1'b0, 0,    0,    1'b0};
        vecs[3] = '{3,    1, 1, 2, 1'b0, 35,   0,    1'b1};
        vecs[4] = '{6,    0, 0, 2, 1'b1, 38,   6,    1'b0};
        vecs[5] = '{1,    0, 0, 2, 1'b0, 33,   1,    1'b0};
        vecs[6] = '{1023, 0, 0, 2, 1'b0, 1055, 1023, 1'b0};

        rst = 1'b1;
        start_i = 1'b0;
        frame_len_i = '0;
        sym_valid_i = 1'b1;
        sym_i = 2'b11;
        core_bit_i = 1'b1;
        core_bit_valid_i = 1'b1;
        clear_rec();
        repeat (3) @(negedge clk);
        #1;
        chk("reset busy", busy_o, 0);
        chk("reset done", done_o, 0);
        chk("reset timeout", timeout_o, 0);
        chk("reset core_clr", core_clr_o, 0);
        chk("reset core_valid", core_valid_o, 0);
        chk("reset core_data", core_data_o, 0);
        chk("reset sym_ready", sym_ready_o, 0);
        chk("reset bit_valid", bit_valid_o, 0);
        chk("reset last", last_o, 0);
        chk("reset bit", bit_o, 0);
        @(negedge clk);
        rst = 1'b0;
        sym_valid_i = 1'b0;

        for (int v = 0; v < 7; v++) begin
            tag = $sformatf("vec%0d", v);
            run_frame(tag, vecs[v].len, vecs[v].gap, vecs[v].mode, vecs[v].den, vecs[v].inj);
            chk({tag, " tbl_core_valid"}, fwd_q.size(), vecs[v].exp_cv);
            chk({tag, " tbl_bits"}, out_q.size(), vecs[v].exp_bits);
            chk({tag, " tbl_timeout"}, n_to, vecs[v].exp_to);
        end

        // Asynchronous reset in the middle of FLUSH aborts the frame.
        clear_rec();
        core_mode = 0;
        gap = 0;
        gap_left = 0;
        src_q.delete();
        for (int i = 0; i < 6; i++) src_q.push_back(2'($urandom));
        cycle(1'b1, 6);
        for (int k = 0; k < 100 && flush_cyc < 0; k++) cycle(1'b0, 0);
        chk("rst_flush reached", (flush_cyc >= 0) ? 1 : 0, 1);
        cycle(1'b0, 0);
        cycle(1'b0, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_flush outputs",
            {busy_o, done_o, timeout_o, core_clr_o, core_valid_o, core_data_o, sym_ready_o,
             bit_valid_o, last_o, bit_o}, 0);
        @(negedge clk);
        rst = 1'b0;
        clear_rec();
        for (int i = 0; i < 60; i++) cycle(1'b0, 0);
        chk("rst_flush no_done", n_done, 0);
        chk("rst_flush no_bits", out_q.size(), 0);
        chk("rst_flush no_core_valid", fwd_q.size(), 0);
        run_frame("after_rst", 3, 0, 0, 2, 1'b0);

        for (int f = 0; f < 25; f++) begin
            r = $urandom_range(0, 9);
            tag = $sformatf("rand%0d", f);
            run_frame(tag, $urandom_range(0, 40), $urandom_range(0, 3),
                      (r < 2) ? 1 : ((r < 5) ? 0 : 2), $urandom_range(1, 8),
                      1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/viterbi_frame_ctrl.md
VITERBI_FRAME_CTRL -- requirements
Module: viterbi_frame_ctrl

Interface
REQ-001 Parameter TBL, default 32, traceback/register-exchange depth of the core; also the flush length in symbols.
REQ-002 Parameter LEN_W, default 10, width of the frame-length field.
REQ-003 Parameter DRAIN_MAX, default 4*TBL, drain-timeout limit in cycles.
REQ-004 clk  in  1  single clock; all logic rising-edge.
REQ-005 rst  in  1  reset, asynchronous and active-high.
REQ-006 start_i  in  1  request to begin a frame; sampled only in IDLE.
REQ-007 frame_len_i  in  LEN_W  number of information bits in the frame; sampled with start_i.
REQ-008 sym_valid_i  in  1  upstream symbol valid.
REQ-009 sym_i  in  2  upstream coded symbol pair.
REQ-010 sym_ready_o  out  1  controller accepts a symbol this cycle.
REQ-011 core_valid_o  out  1  symbol strobe to the Viterbi core.
REQ-012 core_data_o  out  2  symbol to the Viterbi core.
REQ-013 core_clr_o  out  1  one-cycle clear of core path metrics and survivor registers.
REQ-014 core_bit_i  in  1  decoded bit from the core.
REQ-015 core_bit_valid_i  in  1  decoded-bit strobe from the core.
REQ-016 bit_o, bit_valid_o, last_o  out  1 each  decoded bit, strobe, last-bit-of-frame flag.
REQ-017 busy_o, done_o, timeout_o  out  1 each  frame in progress; one-cycle completion pulse; one-cycle drain-timeout pulse.

Function
REQ-018 States SHALL be IDLE, CLEAR, FEED, FLUSH, DRAIN, DONE.
REQ-019 IDLE: start_i=1 with frame_len_i!=0 latches the length, zeroes in_cnt/out_cnt, goes to CLEAR; start_i with length 0 goes to DONE directly, with no core traffic.
REQ-020 CLEAR: lasts exactly one cycle with core_clr_o=1, then goes to FEED.
REQ-021 FEED: sym_ready_o=1; each cycle with sym_valid_i=1 forwards sym_i as core_data_o with core_valid_o=1 in the same cycle (combinational pass-through, zero latency) and increments in_cnt.
REQ-022 FEED: when the accepted symbol makes in_cnt equal the latched length, go to FLUSH; sym_ready_o is 0 in all states other than FEED.
REQ-023 FLUSH: drive core_valid_o=1 with core_data_o=2'b00 for exactly TBL consecutive cycles, then go to DRAIN.
REQ-024 Output forwarding (FEED/FLUSH/DRAIN): each core_bit_valid_i while out_cnt<length SHALL produce bit_valid_o=1 and bit_o=core_bit_i registered one cycle later, and increment out_cnt; strobes with out_cnt>=length are discarded.
REQ-025 last_o=1 with the bit_valid_o of the bit where out_cnt reaches length; it is never asserted otherwise.
REQ-026 DRAIN: go to DONE when out_cnt==length; a wait counter of at least clog2(DRAIN_MAX+1) bits reaching DRAIN_MAX first pulses timeout_o and goes to DONE.
REQ-027 DONE: done_o=1 for one cycle, then IDLE; busy_o=1 in every state except IDLE.
REQ-028 start_i outside IDLE is ignored, with no latch and no state change.
REQ-029 Counters are LEN_W bits wide and never wrap, since length<=2^LEN_W-1.
REQ-030 If core_bit_valid_i arrives in the same cycle as the FEED->FLUSH transition, it is counted; all transition and count events in one cycle apply together.

Reset
REQ-031 rst=1 at any time, including mid-frame, SHALL force IDLE, zero all counters and drive every output to 0; the frame is aborted without done_o.
REQ-032 After reset release, the first start_i begins a fresh frame; the core is re-cleared by CLEAR.

Structure
REQ-033 A shared package viterbi_pkg SHALL hold the state enumeration, the TBL default and the LEN_W default, for reuse by the core and the testbench.
REQ-034 One sub-module is natural: viterbi_frame_cnt, a parameterised up-counter with clear, enable and terminal-match output, instantiated for in_cnt, out_cnt and the flush/wait counter.

Verification
REQ-035 Length 8, eight back-to-back symbols, core model latency TBL: exactly one core_clr_o, then 8+32 core_valid_o, 8 bit_valid_o with last_o on the 8th, and a single done_o.
REQ-036 Length 5 with sym_valid_i gaps of 3 cycles: core_valid_o only on accepted cycles, in_cnt reaches 5, and FLUSH starts the cycle after the 5th symbol.
REQ-037 Length 0: done_o one cycle after start_i, with no core_clr_o, core_valid_o or bit_valid_o.
REQ-038 Core model never asserts core_bit_valid_i: timeout_o and done_o pulse together exactly DRAIN_MAX cycles after entry to DRAIN.
REQ-039 rst asserted in FLUSH: all outputs go to 0 asynchronously and no done_o follows; the next start_i with length 3 completes normally.
REQ-040 start_i pulsed during FEED: no effect, and the original length is still honoured.
